rx_frame_assembler: RTL

// Receive-side counterpart of the transmit frame path: takes 12-bit RGB444 pixel words recovered by the
// CC1200 SPI receiver (RxData/RxValid/FrameSync) and rebuilds a 24-bit AXI4-Stream video frame.

---
 rtl/rx_frame_assembler_pkg.sv | 26 ++
 rtl/rx_pix_fifo.sv | 71 +++++++
 rtl/rx_frame_assembler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_assembler_pkg.sv
// Shared definitions for the receive frame assembler.
// Contents:
//   - pixel widths for RGB444 input and RGB888 output
//   - bit offsets of the {sof, eol, pix[11:0]} FIFO entry
//   - write-side FSM state enum
//   - RGB444 -> RGB888 nibble-replication helper
package rx_frame_assembler_pkg;

  localparam int RGB444_W      = 12;
  localparam int RGB888_W      = 24;
  localparam int ENTRY_W       = 14;
  localparam int ENTRY_EOL_BIT = 12;
  localparam int ENTRY_SOF_BIT = 13;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } wr_state_e;

  // Each 4-bit channel is widened to 8 bits by repeating the nibble, so
  // 4'hF maps to 8'hFF and 4'h0 maps to 8'h00.
  function automatic logic [RGB888_W-1:0] rgb444_to_rgb888(input logic [RGB444_W-1:0] pix);
    return {pix[11:8], pix[11:8], pix[7:4], pix[7:4], pix[3:0], pix[3:0]};
  endfunction

endpackage

// File: rtl/rx_pix_fifo.sv
// Synchronous pixel FIFO, 2**AW entries of W bits.
// The head entry is read straight out of the storage flops, so it is valid
// in the cycle after it is written and needs no read request.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset (empties the FIFO)
//   push        write request; accepted when not full or when popping in the same cycle
//   push_data   entry to write
//   pop         read request; ignored when empty
//   rd_data     head entry (meaningful only when !empty)
//   full/empty  occupancy status
module rx_pix_fifo #(
  parameter int AW = 4,
  parameter int W  = 14
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == {(AW+1){1'b0}});
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rx_frame_assembler.sv
// Rebuilds AXI4-Stream video frames from RGB444 pixel words delivered by
// the radio receiver.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   RxData/RxValid       12-bit pixel word and its one-cycle qualifier
//   FrameSync            one-cycle start-of-frame pulse
//   ClrErr               clears the sticky Overflow/ShortFrame flags
//   m_axis_video_*       24-bit AXIS master (tuser = first pixel, tlast = end of line)
//   FrameDone            pulse when the last pixel of a frame is written to the FIFO
//   FrameCount           completed frames, wrapping
//   Overflow             sticky: a word was dropped because the FIFO was full
//   ShortFrame           sticky: FrameSync cut an incomplete frame short
module rx_frame_assembler
  import rx_frame_assembler_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [RGB444_W-1:0] RxData,
  input  logic                RxValid,
  input  logic                FrameSync,
  input  logic                ClrErr,
  output logic [RGB888_W-1:0] m_axis_video_tdata,
  output logic                m_axis_video_tvalid,
  input  logic                m_axis_video_tready,
  output logic                m_axis_video_tuser,
  output logic                m_axis_video_tlast,
  output logic                FrameDone,
  output logic [15:0]         FrameCount,
  output logic                Overflow,
  output logic                ShortFrame
);

  localparam int PIX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);

  // Input stage
  logic [RGB444_W-1:0] rx_data_q;
  logic                rx_valid_q;
  logic                rx_sync_q;

  // Write-side FSM, counters and status
  wr_state_e          state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               sof_pend_q, sof_pend_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               frame_done_q, frame_done_d;
  logic               short_q, short_d;
  logic               ovf_q, ovf_d;
  logic               short_evt_s, ovf_evt_s;

  // FIFO interface
  logic               wr_en_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;
  logic               fifo_full_s, fifo_empty_s;
  logic               pop_s, fifo_room_s;

  assign pop_s       = !fifo_empty_s && m_axis_video_tready;
  assign fifo_room_s = !fifo_full_s || pop_s;

  // Input register: one cycle of alignment for the radio-side signals.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data_q  <= {RGB444_W{1'b0}};
      rx_valid_q <= 1'b0;
      rx_sync_q  <= 1'b0;
    end else begin
      rx_data_q  <= RxData;
      rx_valid_q <= RxValid;
      rx_sync_q  <= FrameSync;
    end
  end

  // Write FSM: a sync is applied before a word arriving in the same cycle, so that
  // word becomes pixel 0. Counters advance even when the FIFO drops the word.
  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    line_d        = line_q;
    sof_pend_d    = sof_pend_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    wr_en_s       = 1'b0;
    wr_entry_s    = {ENTRY_W{1'b0}};
    short_evt_s   = 1'b0;
    ovf_evt_s     = 1'b0;

    if (rx_sync_q) begin
      short_evt_s = (state_q == ACTIVE);
      state_d     = ACTIVE;
      pix_d       = {PIX_W{1'b0}};
      line_d      = {LINE_W{1'b0}};
      sof_pend_d  = 1'b1;
    end else begin
      state_d = state_q;
    end

    if (rx_valid_q && (state_d == ACTIVE)) begin
      wr_en_s    = 1'b1;
      wr_entry_s = {sof_pend_d, (pix_d == LAST_PIX), rx_data_q};
      // A dropped start-of-frame word leaves sof pending for the next stored word.
      if (fifo_room_s) begin
        sof_pend_d = 1'b0;
      end else begin
        ovf_evt_s = 1'b1;
      end
      if (pix_d == LAST_PIX) begin
        pix_d = {PIX_W{1'b0}};
        if (line_d == LAST_LINE) begin
          line_d        = {LINE_W{1'b0}};
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = WAIT_SYNC;
        end else begin
          line_d = line_d + {{(LINE_W-1){1'b0}}, 1'b1};
        end
      end else begin
        pix_d = pix_d + {{(PIX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      wr_en_s = 1'b0;
    end

    // Sticky flags: a new error event wins over a same-cycle clear.
    if (short_evt_s) begin
      short_d = 1'b1;
    end else if (ClrErr) begin
      short_d = 1'b0;
    end else begin
      short_d = short_q;
    end
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (ClrErr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Write FSM, counter and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= WAIT_SYNC;
      pix_q         <= {PIX_W{1'b0}};
      line_q        <= {LINE_W{1'b0}};
      sof_pend_q    <= 1'b0;
      frame_count_q <= 16'd0;
      frame_done_q  <= 1'b0;
      short_q       <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      line_q        <= line_d;
      sof_pend_q    <= sof_pend_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      short_q       <= short_d;
      ovf_q         <= ovf_d;
    end
  end

  rx_pix_fifo #(
    .AW (FIFO_AW),
    .W  (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (wr_en_s),
    .push_data (wr_entry_s),
    .pop       (pop_s),
    .rd_data   (rd_entry_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // AXIS mapping; payload is forced to zero while the FIFO is empty.
  assign m_axis_video_tvalid = !fifo_empty_s;
  assign m_axis_video_tdata  = fifo_empty_s ? {RGB888_W{1'b0}}
                                            : rgb444_to_rgb888(rd_entry_s[RGB444_W-1:0]);
  assign m_axis_video_tuser  = !fifo_empty_s && rd_entry_s[ENTRY_SOF_BIT];
  assign m_axis_video_tlast  = !fifo_empty_s && rd_entry_s[ENTRY_EOL_BIT];

  assign FrameDone  = frame_done_q;
  assign FrameCount = frame_count_q;
  assign Overflow   = ovf_q;
  assign ShortFrame = short_q;

endmodule
